text_overlay: RTL

//  Parametrised text-window renderer between vga_sync and the VGA pins.
//  - Holds a COLS x ROWS character/colour buffer, loaded through a valid/ready write port.
//  - Draws the window at (ORIG_X, ORIG_Y) with integer zoom, using an external 1-cycle font ROM.
//  - Delays hsync/vsync to match the pixel pipeline.

---
 rtl/text_overlay.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/text_overlay.sv
// text_overlay: COLS x ROWS text window over vga_sync timing; hsync/vsync/rgb come out 3 px_clk after the pixel input.
// Writes are only accepted in blanking once CLEAR has finished (wr_ready low otherwise); define CURSOR_BLINK_EN for a blinking cursor.
module text_overlay #(
  parameter int         COLS   = 16,
  parameter int         ROWS   = 4,
  parameter int         ZOOM   = 1,
  parameter int         ORIG_X = 0,
  parameter int         ORIG_Y = 0,
  parameter logic [2:0] BG     = 3'b000
) (
  input  logic       px_clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       activevideo_in,
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [5:0] wr_col,
  input  logic [4:0] wr_row,
  input  logic [7:0] wr_char,
  input  logic [2:0] wr_color,
  output logic [7:0] glyph_char,
  output logic [2:0] glyph_row,
  input  logic [7:0] glyph_bits,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  localparam int          NCELL = COLS * ROWS;
  localparam int          AW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int          SH    = 3 + ZOOM;
  localparam logic [10:0] OX    = 11'(ORIG_X);
  localparam logic [10:0] OY    = 11'(ORIG_Y);
  localparam logic [10:0] CW    = 11'(COLS);
  localparam logic [10:0] RH    = 11'(ROWS);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   clr_idx;
  logic            last_clr;
  logic [10:0]     mem [NCELL];  // {char, colour}
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [10:0]     mem_wd;
  logic            wr_in_range;
  logic            wr_fire;
  logic [10:0]     wr_addr;

  assign last_clr    = (clr_idx == AW'(NCELL - 1));
  assign wr_in_range = ({1'b0, wr_col} < 7'(COLS)) && ({1'b0, wr_row} < 6'(ROWS));
  assign wr_addr     = 11'(wr_row) * CW + 11'(wr_col);
  assign wr_fire     = wr_valid && wr_ready && wr_in_range;

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && last_clr) state_nxt = IDLE;
  end

  always_comb begin
    wr_ready = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = clr_idx;
    mem_wd   = {8'h20, 3'b111};
    case (state)
      CLEAR: mem_we = 1'b1;
      IDLE: begin
        // single-port buffer: the display owns it during active video
        wr_ready = !activevideo_in;
        mem_we   = wr_valid && !activevideo_in && wr_in_range;
        mem_wa   = AW'(wr_addr);
        mem_wd   = {wr_char, wr_color};
      end
      default: ;
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // 12-bit differences: the borrow bit flags px < origin without wrap-around
  logic [11:0]   dxw;
  logic [11:0]   dyw;
  logic [10:0]   cx;
  logic [10:0]   cy;
  logic          win0;
  logic          cur0;
  logic [AW-1:0] rd_addr;

  assign dxw     = {2'b00, px_x} - {1'b0, OX};
  assign dyw     = {2'b00, px_y} - {1'b0, OY};
  assign cx      = dxw[10:0] >> SH;
  assign cy      = dyw[10:0] >> SH;
  assign win0    = !dxw[11] && (cx < CW) && !dyw[11] && (cy < RH) && (state == IDLE);
  assign rd_addr = win0 ? AW'(cy * CW + cx) : '0;

`ifdef CURSOR_BLINK_EN
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic [5:0] frame_cnt;
  logic       vs_d;

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      cur_col   <= '0;
      cur_row   <= '0;
      frame_cnt <= '0;
      vs_d      <= 1'b0;
    end else begin
      vs_d <= vsync_in;
      if (vs_d && !vsync_in) frame_cnt <= frame_cnt + 1'b1;
      if (wr_fire) begin
        if (wr_col == 6'(COLS - 1)) begin
          cur_col <= '0;
          cur_row <= (wr_row == 5'(ROWS - 1)) ? 5'd0 : wr_row + 1'b1;
        end else begin
          cur_col <= wr_col + 1'b1;
          cur_row <= wr_row;
        end
      end
    end
  end

  assign cur0 = (cx == 11'(cur_col)) && (cy == 11'(cur_row)) && frame_cnt[5];
`else
  assign cur0 = 1'b0;
`endif

  logic        s1_hs, s1_vs, s1_av, s1_win, s1_cur;
  logic [2:0]  s1_colbit, s1_grow;
  logic [10:0] s1_cell;
  logic        s2_hs, s2_vs, s2_av, s2_win, s2_cur;
  logic [2:0]  s2_colbit, s2_color;
  logic        pix_bit;

  always_ff @(posedge px_clk) begin
    s1_cell <= mem[rd_addr];
  end

  assign pix_bit = glyph_bits[3'd7 - s2_colbit] ^ s2_cur;

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      s1_hs <= 1'b0; s1_vs <= 1'b0; s1_av <= 1'b0; s1_win <= 1'b0; s1_cur <= 1'b0;
      s1_colbit <= '0; s1_grow <= '0;
      s2_hs <= 1'b0; s2_vs <= 1'b0; s2_av <= 1'b0; s2_win <= 1'b0; s2_cur <= 1'b0;
      s2_colbit <= '0; s2_color <= '0;
      glyph_char <= '0; glyph_row <= '0;
      hsync <= 1'b0; vsync <= 1'b0; rgb <= BG;
    end else begin
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      s1_av     <= activevideo_in;
      s1_win    <= win0;
      s1_cur    <= cur0;
      s1_colbit <= 3'(dxw[10:0] >> ZOOM);
      s1_grow   <= 3'(dyw[10:0] >> ZOOM);

      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
      s2_av      <= s1_av;
      s2_win     <= s1_win;
      s2_cur     <= s1_cur;
      s2_colbit  <= s1_colbit;
      s2_color   <= s1_cell[2:0];
      glyph_char <= s1_win ? s1_cell[10:3] : 8'h00;
      glyph_row  <= s1_win ? s1_grow : 3'd0;

      hsync <= s2_hs;
      vsync <= s2_vs;
      rgb   <= (s2_av && s2_win && pix_bit) ? s2_color : BG;
    end
  end

endmodule
